// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_sequencer
//  Brief    : Initiator-side MAC controller for a DSP48A1-style slice. Accepts
//             a command (term count, add/sub) and a stream of operand pairs,
//             drives slice A/B/OPMODE with OPMODE aligned to the slice
//             pipeline, and returns one accumulated P/CARRYOUT per command.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_sequencer #(
  parameter int LAT     = 3,  // edges from A/B load to P holding that term
  parameter int OPM_DLY = 1   // edges from A/B load to OPMODE load (>= 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_len_i,
  input  logic        cmd_sub_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [17:0] op_a_i,
  input  logic [17:0] op_b_i,
  output logic [17:0] dsp_a_o,
  output logic [17:0] dsp_b_o,
  output logic [7:0]  dsp_opmode_o,
  input  logic [47:0] dsp_p_i,
  input  logic        dsp_carryout_i,
  output logic        res_valid_o,
  output logic [47:0] res_data_o,
  output logic        res_carry_o
);

  // z=P, x=0, add: leaves P unchanged
  localparam logic [7:0] C_OPM_HOLD = 8'h08;

  localparam int C_DCNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);
  localparam logic [C_DCNT_W-1:0] C_DCNT_LAT = C_DCNT_W'(LAT);
  localparam logic [C_DCNT_W-1:0] C_DCNT_ONE = C_DCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            rem_q, rem_d;
  logic                  sub_q, sub_d;
  logic                  first_q, first_d;
  logic [C_DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [17:0]           a_q, a_d;
  logic [17:0]           b_q, b_d;
  logic                  res_valid_q, res_valid_d;
  logic [47:0]           res_data_q, res_data_d;
  logic                  res_carry_q, res_carry_d;
  logic [7:0]            opm_in_d;       // code entering the OPMODE delay chain
  logic [7:0]            opm_chain_q [OPM_DLY];
  logic [7:0]            opmode_q;

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign op_ready_o   = (state_q == S_ISSUE);
  assign dsp_a_o      = a_q;
  assign dsp_b_o      = b_q;
  assign dsp_opmode_o = opmode_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_carry_o  = res_carry_q;

  // Next-state logic: command intake, term issue with OPMODE selection, drain and capture
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sub_d       = sub_q;
    first_d     = first_q;
    dcnt_d      = dcnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    opm_in_d    = C_OPM_HOLD;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          rem_d   = cmd_len_i;
          sub_d   = cmd_sub_i;
          first_d = 1'b1;
          if (cmd_len_i == 8'd0) begin
            // Empty command: answer zero immediately without touching the slice
            res_data_d  = 48'd0;
            res_carry_d = 1'b0;
            res_valid_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (op_valid_i) begin
          a_d      = op_a_i;
          b_d      = op_b_i;
          // [7]=subtract, [3:2]=z (00 zero on first term, 10 P after), [1:0]=x=M
          opm_in_d = {sub_q, 3'b000, ~first_q, 3'b001};
          first_d  = 1'b0;
          rem_d    = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d = S_DRAIN;
            dcnt_d  = C_DCNT_LAT;
          end
        end
      end

      S_DRAIN: begin
        if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - C_DCNT_ONE;
        end else begin
          res_data_d  = dsp_p_i;
          res_carry_d = dsp_carryout_i;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= 8'd0;
      sub_q       <= 1'b0;
      first_q     <= 1'b0;
      dcnt_q      <= '0;
      a_q         <= 18'd0;
      b_q         <= 18'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 48'd0;
      res_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      sub_q       <= sub_d;
      first_q     <= first_d;
      dcnt_q      <= dcnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
    end
  end

  // OPMODE delay chain: a code queued at the A/B load edge reaches dsp_opmode OPM_DLY edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OPM_DLY; i++) opm_chain_q[i] <= C_OPM_HOLD;
      opmode_q <= C_OPM_HOLD;
    end else begin
      opm_chain_q[0] <= opm_in_d;
      for (int i = 1; i < OPM_DLY; i++) opm_chain_q[i] <= opm_chain_q[i-1];
      opmode_q <= opm_chain_q[OPM_DLY-1];
    end
  end

endmodule
`default_nettype wire
